// File: rtl/backprop_pkg.sv
// Shared definitions for the backpropagation datapath: vector geometry,
// layer addressing and the weight-update sequencer state encoding.
package backprop_pkg;

    localparam int BP_NEURON_NUM          = 4;
    localparam int BP_NEURON_OUTPUT_WIDTH = 10;
    localparam int BP_DELTA_CELL_WIDTH    = 10;
    localparam int BP_LAYER_ADDR_WIDTH    = 2;

    // Flattened vector widths, also used by weight_controller's ports.
    localparam int BP_Z_VEC_WIDTH     = BP_NEURON_NUM * BP_NEURON_OUTPUT_WIDTH;
    localparam int BP_DELTA_VEC_WIDTH = BP_NEURON_NUM * BP_DELTA_CELL_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT_W = 3'd3,
        S_NEXT   = 3'd4
    } seq_state_e;

endpackage

// File: rtl/vector_holding_reg.sv
// Single-entry ready/valid capture register: accepts one beat while capture_en
// is high and replays it on the output side while issue_en is high.
module vector_holding_reg #(
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture_en,
    input  logic             issue_en,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             full
);

    logic [WIDTH-1:0] data_q;
    logic             full_q;

    // NOTE: every signal driven from always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        in_ready  = capture_en & ~full_q;
        out_valid = issue_en & full_q;
        out_data  = data_q;
        full      = full_q;
    end

    // NOTE: the data register is reset as well, so the issue bus reads 0 straight out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (flush) begin
            full_q <= 1'b0;
        end else if (in_valid && in_ready) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            full_q <= 1'b1;
            data_q <= in_data;
        end else if (out_valid && out_ready) begin
            full_q <= 1'b0;
        end
    end

endmodule

// File: rtl/weight_update_sequencer.sv
// Walks the weight-update pass from top_layer down to layer 0, feeding one z and
// one delta vector per layer to weight_controller, with a stall watchdog.
module weight_update_sequencer
    import backprop_pkg::*;
#(
    parameter int NEURON_NUM          = BP_NEURON_NUM,
    parameter int NEURON_OUTPUT_WIDTH = BP_NEURON_OUTPUT_WIDTH,
    parameter int DELTA_CELL_WIDTH    = BP_DELTA_CELL_WIDTH,
    parameter int LAYER_ADDR_WIDTH    = BP_LAYER_ADDR_WIDTH,
    parameter int TIMEOUT_WIDTH       = 8
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [LAYER_ADDR_WIDTH-1:0]               top_layer,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      error_seen,
    output logic                                      timeout,
    input  logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0] z_src,
    input  logic                                      z_src_valid,
    output logic                                      z_src_ready,
    input  logic [NEURON_NUM*DELTA_CELL_WIDTH-1:0]    delta_src,
    input  logic                                      delta_src_valid,
    output logic                                      delta_src_ready,
    output logic [LAYER_ADDR_WIDTH-1:0]               src_layer,
    output logic [LAYER_ADDR_WIDTH-1:0]               wc_layer,
    output logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0] wc_z,
    output logic                                      wc_z_valid,
    input  logic                                      wc_z_ready,
    output logic [NEURON_NUM*DELTA_CELL_WIDTH-1:0]    wc_delta,
    output logic                                      wc_delta_valid,
    input  logic                                      wc_delta_ready,
    input  logic                                      wc_w_valid,
    output logic                                      wc_w_ready,
    input  logic                                      w_sink_ready,
    input  logic                                      wc_error
);

    localparam int Z_W = NEURON_NUM * NEURON_OUTPUT_WIDTH;
    localparam int D_W = NEURON_NUM * DELTA_CELL_WIDTH;

    localparam logic [TIMEOUT_WIDTH-1:0]    WD_ONE   = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [TIMEOUT_WIDTH-1:0]    WD_LAST  = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [LAYER_ADDR_WIDTH-1:0] LAYER_ONE = {{(LAYER_ADDR_WIDTH-1){1'b0}}, 1'b1};

    seq_state_e state, state_adv, state_nxt;

    logic [LAYER_ADDR_WIDTH-1:0] cur_layer;
    logic [TIMEOUT_WIDTH-1:0]    wd_cnt;
    logic                        wd_hit;

    logic capture_en, issue_en, flush;
    logic z_full, d_full;
    logic z_src_hs, d_src_hs, wc_z_hs, wc_d_hs, w_hs, any_hs;
    logic start_ok;

    vector_holding_reg #(.WIDTH(Z_W)) u_z_hold (
        .clk        (clk),
        .rst        (rst),
        .capture_en (capture_en),
        .issue_en   (issue_en),
        .flush      (flush),
        .in_data    (z_src),
        .in_valid   (z_src_valid),
        .in_ready   (z_src_ready),
        .out_data   (wc_z),
        .out_valid  (wc_z_valid),
        .out_ready  (wc_z_ready),
        .full       (z_full)
    );

    vector_holding_reg #(.WIDTH(D_W)) u_delta_hold (
        .clk        (clk),
        .rst        (rst),
        .capture_en (capture_en),
        .issue_en   (issue_en),
        .flush      (flush),
        .in_data    (delta_src),
        .in_valid   (delta_src_valid),
        .in_ready   (delta_src_ready),
        .out_data   (wc_delta),
        .out_valid  (wc_delta_valid),
        .out_ready  (wc_delta_ready),
        .full       (d_full)
    );

    always_comb begin
        z_src_hs = z_src_valid & z_src_ready;
        d_src_hs = delta_src_valid & delta_src_ready;
        wc_z_hs  = wc_z_valid & wc_z_ready;
        wc_d_hs  = wc_delta_valid & wc_delta_ready;
        w_hs     = wc_w_valid & wc_w_ready;
        any_hs   = z_src_hs | d_src_hs | wc_z_hs | wc_d_hs | w_hs;
        start_ok = (state == S_IDLE) & start;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // The watchdog abort overrides whatever the normal flow would do this cycle.
    always_comb begin
        state_adv = state;
        case (state)
            S_IDLE:   if (start) state_adv = S_LOAD;
            S_LOAD:   if ((z_full | z_src_hs) && (d_full | d_src_hs)) state_adv = S_ISSUE;
            S_ISSUE:  if ((!z_full | wc_z_hs) && (!d_full | wc_d_hs)) state_adv = S_WAIT_W;
            S_WAIT_W: if (w_hs) state_adv = S_NEXT;
            S_NEXT:   state_adv = (cur_layer == '0) ? S_IDLE : S_LOAD;
            default:  state_adv = S_IDLE;
        endcase
        wd_hit    = (state != S_IDLE) && (state_adv == state) && !any_hs && (wd_cnt == WD_LAST);
        state_nxt = wd_hit ? S_IDLE : state_adv;
    end

    always_comb begin
        capture_en = (state == S_LOAD);
        issue_en   = (state == S_ISSUE);
        flush      = (state == S_IDLE);
        wc_w_ready = (state == S_WAIT_W) & w_sink_ready;
        src_layer  = cur_layer;
        wc_layer   = cur_layer;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_layer <= '0;
        end else if (start_ok) begin
            cur_layer <= top_layer;
        end else if (state == S_NEXT && state_nxt == S_LOAD) begin
            cur_layer <= cur_layer - LAYER_ONE;
        end
    end

    // Any progress (state change or handshake) restarts the stall count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
        end else if (state == S_IDLE || state_nxt != state || any_hs) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WD_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            error_seen <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            busy <= (state_nxt != S_IDLE);
            done <= (state != S_IDLE) && (state_nxt == S_IDLE);
            if (start_ok)             error_seen <= 1'b0;
            else if (busy && wc_error) error_seen <= 1'b1;
            if (start_ok)    timeout <= 1'b0;
            else if (wd_hit) timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_weight_update_sequencer.sv
// Directed bench for weight_update_sequencer: a cycle table for the nominal pass
// plus hand-written sequences for skew, backpressure, watchdog, error and reset.
module tb_weight_update_sequencer;

    localparam int ZW = 40;
    localparam int DW = 40;
    localparam logic [ZW-1:0] ZV = {10'd800, 10'd700, 10'd600, 10'd500};
    localparam logic [DW-1:0] DV = {10'd4, 10'd3, 10'd2, 10'd1};
    localparam logic [ZW-1:0] ZB = {10'd11, 10'd22, 10'd33, 10'd44};
    localparam logic [DW-1:0] DB = {10'd5, 10'd6, 10'd7, 10'd8};
    localparam logic [ZW-1:0] ZC = {10'd101, 10'd202, 10'd303, 10'd404};

    logic clk, rst, start;
    logic [1:0] top_layer;
    logic [ZW-1:0] z_src;
    logic [DW-1:0] delta_src;
    logic z_src_valid, delta_src_valid, wc_z_ready, wc_delta_ready;
    logic wc_w_valid, w_sink_ready, wc_error;

    logic busy, done, error_seen, timeout, z_src_ready, delta_src_ready;
    logic [1:0] src_layer, wc_layer;
    logic [ZW-1:0] wc_z;
    logic [DW-1:0] wc_delta;
    logic wc_z_valid, wc_delta_valid, wc_w_ready;

    logic busy_s, done_s, error_seen_s, timeout_s, z_src_ready_s, delta_src_ready_s;
    logic [1:0] src_layer_s, wc_layer_s;
    logic [ZW-1:0] wc_z_s;
    logic [DW-1:0] wc_delta_s;
    logic wc_z_valid_s, wc_delta_valid_s, wc_w_ready_s;

    int n_checks = 0;
    int n_err    = 0;

    weight_update_sequencer #(.TIMEOUT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .top_layer(top_layer),
        .busy(busy), .done(done), .error_seen(error_seen), .timeout(timeout),
        .z_src(z_src), .z_src_valid(z_src_valid), .z_src_ready(z_src_ready),
        .delta_src(delta_src), .delta_src_valid(delta_src_valid), .delta_src_ready(delta_src_ready),
        .src_layer(src_layer), .wc_layer(wc_layer),
        .wc_z(wc_z), .wc_z_valid(wc_z_valid), .wc_z_ready(wc_z_ready),
        .wc_delta(wc_delta), .wc_delta_valid(wc_delta_valid), .wc_delta_ready(wc_delta_ready),
        .wc_w_valid(wc_w_valid), .wc_w_ready(wc_w_ready),
        .w_sink_ready(w_sink_ready), .wc_error(wc_error)
    );

    // Short-watchdog copy sharing all inputs; only observed for the timeout case.
    weight_update_sequencer #(.TIMEOUT_WIDTH(4)) dut_s (
        .clk(clk), .rst(rst), .start(start), .top_layer(top_layer),
        .busy(busy_s), .done(done_s), .error_seen(error_seen_s), .timeout(timeout_s),
        .z_src(z_src), .z_src_valid(z_src_valid), .z_src_ready(z_src_ready_s),
        .delta_src(delta_src), .delta_src_valid(delta_src_valid), .delta_src_ready(delta_src_ready_s),
        .src_layer(src_layer_s), .wc_layer(wc_layer_s),
        .wc_z(wc_z_s), .wc_z_valid(wc_z_valid_s), .wc_z_ready(wc_z_ready),
        .wc_delta(wc_delta_s), .wc_delta_valid(wc_delta_valid_s), .wc_delta_ready(wc_delta_ready),
        .wc_w_valid(wc_w_valid), .wc_w_ready(wc_w_ready_s),
        .w_sink_ready(w_sink_ready), .wc_error(wc_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          zr;
        logic          dr;
        logic          zv;
        logic          dv;
        logic          wr;
        logic [1:0]    layer;
        logic [ZW-1:0] z;
        logic [DW-1:0] d;
    } obs_t;

    typedef struct packed {
        logic start;
        obs_t exp;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.busy  = busy;
        o.done  = done;
        o.zr    = z_src_ready;
        o.dr    = delta_src_ready;
        o.zv    = wc_z_valid;
        o.dv    = wc_delta_valid;
        o.wr    = wc_w_ready;
        o.layer = wc_layer;
        o.z     = wc_z;
        o.d     = wc_delta;
        return o;
    endfunction

    // Expected outputs for phase ph: 0 idle, 1 load, 2 issue, 3 wait_w, 4 next.
    function automatic obs_t mk(input int ph, input logic [1:0] layer, input logic dn, input logic data);
        obs_t o;
        o       = '0;
        o.busy  = (ph != 0);
        o.done  = dn;
        o.zr    = (ph == 1);
        o.dr    = (ph == 1);
        o.zv    = (ph == 2);
        o.dv    = (ph == 2);
        o.wr    = (ph == 3);
        o.layer = layer;
        o.z     = data ? ZV : '0;
        o.d     = data ? DV : '0;
        return o;
    endfunction

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        start = 1'b0; top_layer = 2'd0;
        z_src = '0; delta_src = '0;
        z_src_valid = 1'b0; delta_src_valid = 1'b0;
        wc_z_ready = 1'b0; wc_delta_ready = 1'b0;
        wc_w_valid = 1'b0; w_sink_ready = 1'b0; wc_error = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic all_ready();
        z_src_valid = 1'b1; delta_src_valid = 1'b1;
        wc_z_ready = 1'b1; wc_delta_ready = 1'b1;
        wc_w_valid = 1'b1; w_sink_ready = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, mk(0, 2'd0, 1'b0, 1'b0)};
        vecs[1]  = '{1'b0, mk(1, 2'd2, 1'b0, 1'b0)};
        vecs[2]  = '{1'b0, mk(2, 2'd2, 1'b0, 1'b1)};
        vecs[3]  = '{1'b0, mk(3, 2'd2, 1'b0, 1'b1)};
        vecs[4]  = '{1'b0, mk(4, 2'd2, 1'b0, 1'b1)};
        vecs[5]  = '{1'b0, mk(1, 2'd1, 1'b0, 1'b1)};
        vecs[6]  = '{1'b0, mk(2, 2'd1, 1'b0, 1'b1)};
        vecs[7]  = '{1'b0, mk(3, 2'd1, 1'b0, 1'b1)};
        vecs[8]  = '{1'b0, mk(4, 2'd1, 1'b0, 1'b1)};
        vecs[9]  = '{1'b0, mk(1, 2'd0, 1'b0, 1'b1)};
        vecs[10] = '{1'b0, mk(2, 2'd0, 1'b0, 1'b1)};
        vecs[11] = '{1'b0, mk(3, 2'd0, 1'b0, 1'b1)};
        vecs[12] = '{1'b0, mk(4, 2'd0, 1'b0, 1'b1)};
        vecs[13] = '{1'b0, mk(0, 2'd0, 1'b1, 1'b1)};
        vecs[14] = '{1'b0, mk(0, 2'd0, 1'b0, 1'b1)};

        // Nominal 3-layer pass, every partner always ready.
        do_reset();
        @(negedge clk);
        check("reset_outputs", {busy, done, error_seen, timeout, z_src_ready, delta_src_ready,
                                src_layer, wc_layer, wc_z, wc_z_valid, wc_delta, wc_delta_valid, wc_w_ready}, '0);
        adv();
        all_ready();
        top_layer = 2'd2; z_src = ZV; delta_src = DV;
        for (int i = 0; i < 15; i++) begin
            start = vecs[i].start;
            @(negedge clk);
            check($sformatf("pass3_c%0d", i), sample(), vecs[i].exp);
            if (i == 6) check("src_layer_tracks", src_layer, 2'd1);
            adv();
        end
        start = 1'b0;

        // Skewed source and issue handshakes.
        do_reset();
        wc_w_valid = 1'b1; w_sink_ready = 1'b1; top_layer = 2'd0;
        start = 1'b1;
        adv();
        start = 1'b0;
        z_src_valid = 1'b1; z_src = ZB; delta_src = '1;
        @(negedge clk);
        check("skew_load_readies", {z_src_ready, delta_src_ready}, 2'b11);
        adv();
        z_src_valid = 1'b0; z_src = '1;
        @(negedge clk);
        check("skew_z_ready_dropped", {z_src_ready, delta_src_ready, wc_z_valid}, 3'b010);
        repeat (4) adv();
        delta_src_valid = 1'b1; delta_src = DB;
        @(negedge clk);
        check("skew_still_load", {delta_src_ready, wc_z_valid, wc_delta_valid}, 3'b100);
        adv();
        delta_src_valid = 1'b0; delta_src = '0;
        wc_z_ready = 1'b1;
        @(negedge clk);
        check("skew_issue_both", {wc_z_valid, wc_delta_valid, wc_z, wc_delta}, {1'b1, 1'b1, ZB, DB});
        adv();
        wc_z_ready = 1'b0;
        @(negedge clk);
        check("skew_z_valid_dropped", {wc_z_valid, wc_delta_valid, wc_w_ready}, 3'b010);
        adv();
        adv();
        wc_delta_ready = 1'b1;
        @(negedge clk);
        check("skew_no_wait_yet", {wc_delta_valid, wc_w_ready}, 2'b10);
        adv();
        wc_delta_ready = 1'b0;
        @(negedge clk);
        check("skew_wait_w", {wc_z_valid, wc_delta_valid, wc_w_ready}, 3'b001);
        repeat (2) adv();
        @(negedge clk);
        check("skew_done", {done, busy}, 2'b10);

        // Weight-sink backpressure for 20 cycles.
        do_reset();
        all_ready();
        w_sink_ready = 1'b0; top_layer = 2'd1; z_src = ZV; delta_src = DV;
        start = 1'b1;
        adv();
        start = 1'b0;
        repeat (2) adv();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check($sformatf("bp_hold_%0d", k), {wc_w_ready, timeout, busy, wc_layer}, {1'b0, 1'b0, 1'b1, 2'd1});
            adv();
        end
        w_sink_ready = 1'b1;
        @(negedge clk);
        check("bp_release", wc_w_ready, 1'b1);
        adv();
        @(negedge clk);
        check("bp_next", {wc_layer, z_src_ready}, {2'd1, 1'b0});
        adv();
        @(negedge clk);
        check("bp_advanced", {wc_layer, z_src_ready}, {2'd0, 1'b1});
        repeat (4) adv();
        @(negedge clk);
        check("bp_done", {done, busy, timeout}, 3'b100);

        // Watchdog with the 4-bit counter: weight result never arrives.
        do_reset();
        all_ready();
        wc_w_valid = 1'b0; top_layer = 2'd0; z_src = ZV; delta_src = DV;
        start = 1'b1;
        adv();
        start = 1'b0;
        repeat (2) adv();
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check($sformatf("wd_stall_%0d", k), {done_s, timeout_s, busy_s, wc_w_ready_s}, 4'b0011);
            adv();
        end
        @(negedge clk);
        check("wd_abort", {done_s, timeout_s, busy_s, z_src_ready_s, delta_src_ready_s,
                           wc_z_valid_s, wc_delta_valid_s, wc_w_ready_s}, 8'b1100_0000);
        adv();
        @(negedge clk);
        check("wd_after", {done_s, timeout_s, busy_s}, 3'b010);
        check("wd_wide_no_timeout", {timeout, busy, wc_w_ready}, 3'b011);

        // wc_error in layer 1, an ignored mid-pass start, then a restart.
        do_reset();
        all_ready();
        top_layer = 2'd2; z_src = ZV; delta_src = DV;
        start = 1'b1;
        adv();
        start = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            logic [1:0] exp_layer;
            wc_error  = (k == 6);
            start     = (k == 7);
            top_layer = (k == 7) ? 2'd3 : 2'd2;
            exp_layer = (k <= 12) ? 2'(2 - (k - 1) / 4) : 2'd0;
            @(negedge clk);
            check($sformatf("err_c%0d", k), {busy, done, error_seen, wc_layer},
                  {(k <= 12), (k == 13), (k >= 7), exp_layer});
            adv();
        end
        wc_error = 1'b0;
        start = 1'b1; top_layer = 2'd0;
        @(negedge clk);
        check("err_sticky_idle", {error_seen, busy}, 2'b10);
        adv();
        start = 1'b0;
        @(negedge clk);
        check("err_cleared", {error_seen, busy, wc_layer}, {1'b0, 1'b1, 2'd0});
        repeat (4) adv();
        @(negedge clk);
        check("err_restart_done", {done, error_seen}, 2'b10);

        // Reset asserted in ISSUE.
        do_reset();
        all_ready();
        top_layer = 2'd1; z_src = ZB; delta_src = DB;
        start = 1'b1;
        adv();
        start = 1'b0;
        adv();
        #3;
        check("rst_pre_issue", {wc_z_valid, wc_z}, {1'b1, ZB});
        rst = 1'b0;
        #1;
        check("rst_async_zero", {busy, done, error_seen, timeout, z_src_ready, delta_src_ready,
                                 src_layer, wc_layer, wc_z, wc_z_valid, wc_delta, wc_delta_valid, wc_w_ready}, '0);
        adv();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rst_no_done_%0d", k), {done, busy}, 2'b00);
            adv();
        end
        top_layer = 2'd0; z_src = ZC;
        start = 1'b1;
        adv();
        start = 1'b0;
        adv();
        @(negedge clk);
        check("rst_clean_issue", {wc_z_valid, wc_z, wc_delta}, {1'b1, ZC, DB});
        repeat (3) adv();
        @(negedge clk);
        check("rst_clean_done", {done, busy, timeout}, 3'b100);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/weight_update_sequencer.md
# weight_update_sequencer

Sequences the backpropagation weight-update pass across all layers by driving `weight_controller` one layer at a time, from the top layer down to layer 0. Per layer it captures one z vector and one delta vector from upstream buffers, issues them to `weight_controller` with its layer address, and forwards the resulting weight handshake to the weight sink. It sits between the forward/backward activation buffers and `weight_controller`, and reports completion, overflow errors and timeouts to the top-level training FSM.

## Interface
Parameters:
- NEURON_NUM, 4, cells per z/delta vector
- NEURON_OUTPUT_WIDTH, 10, width of each z cell
- DELTA_CELL_WIDTH, 10, width of each delta cell
- LAYER_ADDR_WIDTH, 2, layer address width
- TIMEOUT_WIDTH, 8, width of the watchdog counter; the timeout fires after 2^TIMEOUT_WIDTH-1 stalled cycles

Ports:
- clk  in  1  single clock; all logic is rising-edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a pass; honoured only in IDLE
- top_layer  in  LAYER_ADDR_WIDTH  index of the first (highest) layer; sampled on an accepted start
- busy  out  1  high from an accepted start until done
- done  out  1  one-cycle pulse at the end of a pass (normal or aborted)
- error_seen  out  1  sticky: wc_error was observed during the pass
- timeout  out  1  sticky: the watchdog aborted the pass
- z_src, z_src_valid, z_src_ready  in/in/out  NEURON_NUM*NEURON_OUTPUT_WIDTH/1/1  upstream z stream
- delta_src, delta_src_valid, delta_src_ready  in/in/out  NEURON_NUM*DELTA_CELL_WIDTH/1/1  upstream delta stream
- src_layer  out  LAYER_ADDR_WIDTH  layer that the upstream buffers must present
- wc_layer  out  LAYER_ADDR_WIDTH  layer address to `weight_controller`
- wc_z, wc_z_valid, wc_z_ready  out/out/in  z issue channel
- wc_delta, wc_delta_valid, wc_delta_ready  out/out/in  delta issue channel
- wc_w_valid  in  1;  wc_w_ready  out  1  weight result handshake
- w_sink_ready  in  1  downstream readiness; combined into wc_w_ready
- wc_error  in  1  overflow flag from `weight_controller`

## Operation
- The FSM has five states: IDLE, LOAD, ISSUE, WAIT_W and NEXT.
- IDLE
  - On start: cur_layer <= top_layer; error_seen and timeout are cleared; busy <= 1; go to LOAD.
- LOAD
  - z_src_ready and delta_src_ready are driven independently, each high until its own beat is captured into a holding register.
  - When both vectors are held, go to ISSUE.
- ISSUE
  - wc_z_valid and wc_delta_valid are asserted together with the held data.
  - Each valid drops independently after its own handshake (valid & ready).
  - When both handshakes have completed, go to WAIT_W.
- WAIT_W
  - wc_w_ready = w_sink_ready; it is combinational and only active in this state.
  - The handshake wc_w_valid & wc_w_ready moves the FSM to NEXT.
- NEXT
  - If cur_layer == 0: done pulse, busy <= 0, go to IDLE.
  - Otherwise cur_layer <= cur_layer - 1 and go to LOAD. There is no wrap-around.
- wc_layer and src_layer both equal cur_layer at all times.
- error_seen is set on any cycle where busy and wc_error are both high. It does not abort the pass.
- Watchdog
  - The counter resets on every state change and on every handshake, and increments otherwise while busy.
  - At the all-ones count: timeout <= 1, all valids and readies drop, done pulses, busy <= 0, go to IDLE.
- A start while busy is ignored.

## Timing
- Reset values: every output is 0, the state is IDLE, and the holding registers are 0.
- Latency from start to the first z_src_ready is 1 cycle.
- With all partners always ready, each layer takes 4 cycles (LOAD, ISSUE, WAIT_W, NEXT). A pass takes 4*(top_layer+1)+1 cycles from start to done.
- Once asserted, valids stay high with stable data until their handshake completes (AXI-stream rule).
- z and delta handshakes may complete in the same cycle or in different cycles; both orders are legal.
- If start and rst arrive in the same cycle, rst wins.
- Asserting rst mid-pass returns the block to IDLE immediately. No done pulse is produced, and the held data is discarded.

## Structure
- Shared package `backprop_pkg`:
  - FSM state encoding
  - the layer-address width constant
  - vector-width localparams, shared with `weight_controller`
- One sub-module, `vector_holding_reg`: a single-entry ready/valid capture register. It is instantiated twice, once for z and once for delta.
- The watchdog counter and the FSM are inline.

## Test plan
- Pass over 3 layers, all partners always ready: top_layer=2 with z={800,700,600,500} and delta={4,3,2,1} per layer.
  - wc_layer sequence is 2,1,0.
  - done pulses exactly 13 cycles after start.
  - busy falls with done.
- Skewed handshakes: delta_src_valid lags z by 5 cycles and wc_delta_ready lags wc_z_ready by 3.
  - Each valid drops independently.
  - WAIT_W is entered only after both handshakes have completed.
- Backpressure: w_sink_ready is held low for 20 cycles in WAIT_W.
  - wc_w_ready stays 0.
  - No timeout occurs (TIMEOUT_WIDTH=8).
  - The layer advances one cycle after w_sink_ready rises.
- Watchdog: wc_w_valid is never asserted, with TIMEOUT_WIDTH=4.
  - timeout=1 and done pulses 15 cycles after WAIT_W is entered.
  - All valids are 0 and the block is back in IDLE.
- Error and restart: wc_error is pulsed for 1 cycle in layer 1.
  - error_seen stays set through done.
  - The next start clears it.
  - A start pulse issued mid-pass is ignored (wc_layer sequence unchanged).
- Reset mid-pass: rst is pulled low in ISSUE.
  - All outputs read 0 asynchronously.
  - No done pulse.
  - A new start after release runs a clean pass.
